// File: rtl/dwt_sym_ext_feeder.sv
// Tile capture and symmetric-extension row-pair replay feeding the 9/7 lifting unit's vertical pass.
// Optional macro DWT_SYM_EXT_ERR_EN adds sticky geometry-error flag and discarded-tile counter ports.
module dwt_sym_ext_feeder #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   s_ready_o,
   input  logic                   s_valid_i,
   input  logic                   s_sof_i,
   input  logic                   s_eol_i,
   input  logic [DataWidth-1:0]   s_data_i,
   input  logic                   m_ready_i,
   output logic                   m_valid_o,
   output logic                   m_sof_o,
   output logic                   m_eol_o,
   output logic [2*DataWidth-1:0] m_data_o
`ifdef DWT_SYM_EXT_ERR_EN
   ,
   output logic                   err_o,
   output logic [7:0]             err_cnt_o
`endif
);

   localparam int CW        = $clog2(MaximumSideSize + 1);
   localparam int BankDepth = MaximumSideSize / 2 * MaximumSideSize;
   localparam int AW        = $clog2(BankDepth);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_EMIT = 2'd2} state_t;

   function automatic logic [AW-1:0] bank_addr(input logic [CW-1:0] half, input logic [CW-1:0] col);
      return AW'(int'(half) * MaximumSideSize + int'(col));
   endfunction

   state_t state_q, state_d;
   logic [CW-1:0] row_q, row_d, col_q, col_d, n_q, n_d, k_q, k_d;
   logic issue_done_q, issue_done_d, s_ready_q, s_ready_d;
   logic rd_valid_q, rd_valid_d, rd_sof_q, rd_sof_d, rd_eol_q, rd_eol_d, rd_last_q, rd_last_d;
   logic m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d, m_last_q, m_last_d;
   logic skid_valid_q, skid_valid_d, skid_sof_q, skid_sof_d, skid_eol_q, skid_eol_d, skid_last_q, skid_last_d;
   logic [2*DataWidth-1:0] m_data_q, m_data_d, skid_data_q, skid_data_d;
   logic [DataWidth-1:0] rdata_even_q, rdata_odd_q;
   logic [DataWidth-1:0] mem_even_q [BankDepth];
   logic [DataWidth-1:0] mem_odd_q  [BankDepth];

   logic acc_s, pop_s, free_s, geo_err_s, we_even_s, we_odd_s, rd_en_s;
   logic [1:0] occ_s;
   logic [AW-1:0] wr_addr_s, rd_addr_even_s, rd_addr_odd_s;
   logic [CW-1:0] eff_row_s, eff_col_s, half_n_s, last_col_s, even_half_s, odd_half_s;

   assign acc_s          = s_valid_i & s_ready_q;
   assign pop_s          = m_valid_q & m_ready_i;
   // Slots already committed: head, skid and the read in flight.
   assign occ_s          = {1'b0, m_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q};
   assign free_s         = (occ_s - {1'b0, pop_s}) < 2'd2;
   assign half_n_s       = n_q >> 1;
   assign last_col_s     = n_q - CW'(1);
   assign rd_addr_even_s = bank_addr(even_half_s, col_q);
   assign rd_addr_odd_s  = bank_addr(odd_half_s, col_q);

   always_comb begin
      state_d = state_q;  row_d = row_q;  col_d = col_q;  n_d = n_q;  k_d = k_q;
      issue_done_d = issue_done_q;
      rd_valid_d = 1'b0;  rd_sof_d = rd_sof_q;  rd_eol_d = rd_eol_q;  rd_last_d = rd_last_q;
      we_even_s = 1'b0;  we_odd_s = 1'b0;  wr_addr_s = {AW{1'b0}};  rd_en_s = 1'b0;
      even_half_s = {CW{1'b0}};  odd_half_s = {CW{1'b0}};  geo_err_s = 1'b0;
      if (s_sof_i) begin
         eff_row_s = {CW{1'b0}};
         eff_col_s = {CW{1'b0}};
      end else begin
         eff_row_s = row_q;
         eff_col_s = col_q;
      end
      case (state_q)
         S_IDLE, S_FILL: begin
            if (acc_s && (s_sof_i || (state_q == S_FILL))) begin
               we_even_s = ~eff_row_s[0];
               we_odd_s  = eff_row_s[0];
               wr_addr_s = bank_addr(eff_row_s >> 1, eff_col_s);
               state_d   = S_FILL;
               row_d     = eff_row_s;
               col_d     = eff_col_s + CW'(1);
               if (eff_row_s == {CW{1'b0}}) begin
                  if (s_eol_i) begin
                     n_d = eff_col_s + CW'(1);
                     if ((eff_col_s[0] == 1'b0) || (eff_col_s < CW'(5))) begin
                        geo_err_s = 1'b1;
                     end else begin
                        row_d = CW'(1);
                        col_d = {CW{1'b0}};
                     end
                  end else if (eff_col_s == CW'(MaximumSideSize - 1)) begin
                     geo_err_s = 1'b1;
                  end else begin
                     geo_err_s = 1'b0;
                  end
               end else if (s_eol_i != (eff_col_s == last_col_s)) begin
                  geo_err_s = 1'b1;
               end else if (s_eol_i) begin
                  row_d = eff_row_s + CW'(1);
                  col_d = {CW{1'b0}};
                  if (eff_row_s == last_col_s) begin
                     state_d      = S_EMIT;
                     k_d          = {CW{1'b0}};
                     issue_done_d = 1'b0;
                  end else begin
                     state_d = S_FILL;
                  end
               end else begin
                  geo_err_s = 1'b0;
               end
               if (geo_err_s) begin
                  state_d = S_IDLE;
                  row_d   = {CW{1'b0}};
                  col_d   = {CW{1'b0}};
               end else begin
                  n_d = n_d;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_EMIT: begin
            // Bank row indices (row >> 1) of each {odd, even} pair, including the mirrored edges.
            if (k_q == CW'(0)) begin
               even_half_s = CW'(2);  odd_half_s = CW'(1);
            end else if (k_q == CW'(1)) begin
               even_half_s = CW'(1);  odd_half_s = CW'(0);
            end else if (k_q < half_n_s + CW'(2)) begin
               even_half_s = k_q - CW'(2);  odd_half_s = k_q - CW'(2);
            end else if (k_q == half_n_s + CW'(2)) begin
               even_half_s = half_n_s - CW'(1);  odd_half_s = half_n_s - CW'(2);
            end else begin
               even_half_s = half_n_s - CW'(2);  odd_half_s = half_n_s - CW'(3);
            end
            if (!issue_done_q && free_s) begin
               rd_en_s    = 1'b1;
               rd_valid_d = 1'b1;
               rd_sof_d   = (k_q == CW'(0)) && (col_q == CW'(0));
               rd_eol_d   = (col_q == last_col_s);
               rd_last_d  = (col_q == last_col_s) && (k_q == half_n_s + CW'(3));
               if (col_q == last_col_s) begin
                  col_d        = {CW{1'b0}};
                  k_d          = k_q + CW'(1);
                  issue_done_d = (k_q == half_n_s + CW'(3));
               end else begin
                  col_d = col_q + CW'(1);
               end
            end else begin
               rd_valid_d = 1'b0;
            end
            if (pop_s && m_last_q) begin
               state_d = S_IDLE;
               row_d   = {CW{1'b0}};
               col_d   = {CW{1'b0}};
            end else begin
               state_d = S_EMIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
      s_ready_d = (state_d != S_EMIT);
   end

   always_comb begin
      m_valid_d = m_valid_q;  m_sof_d = m_sof_q;  m_eol_d = m_eol_q;  m_last_d = m_last_q;  m_data_d = m_data_q;
      skid_valid_d = skid_valid_q;  skid_sof_d = skid_sof_q;  skid_eol_d = skid_eol_q;
      skid_last_d = skid_last_q;  skid_data_d = skid_data_q;
      if (pop_s || !m_valid_q) begin
         if (skid_valid_q) begin
            m_valid_d = 1'b1;  m_sof_d = skid_sof_q;  m_eol_d = skid_eol_q;
            m_last_d = skid_last_q;  m_data_d = skid_data_q;
            skid_valid_d = rd_valid_q;  skid_sof_d = rd_sof_q;  skid_eol_d = rd_eol_q;
            skid_last_d = rd_last_q;  skid_data_d = {rdata_odd_q, rdata_even_q};
         end else if (rd_valid_q) begin
            m_valid_d = 1'b1;  m_sof_d = rd_sof_q;  m_eol_d = rd_eol_q;
            m_last_d = rd_last_q;  m_data_d = {rdata_odd_q, rdata_even_q};
         end else begin
            m_valid_d = 1'b0;  m_sof_d = 1'b0;  m_eol_d = 1'b0;  m_last_d = 1'b0;
         end
      end else if (rd_valid_q) begin
         skid_valid_d = 1'b1;  skid_sof_d = rd_sof_q;  skid_eol_d = rd_eol_q;
         skid_last_d = rd_last_q;  skid_data_d = {rdata_odd_q, rdata_even_q};
      end else begin
         skid_valid_d = skid_valid_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;  row_q <= {CW{1'b0}};  col_q <= {CW{1'b0}};  n_q <= {CW{1'b0}};  k_q <= {CW{1'b0}};
         issue_done_q <= 1'b0;  s_ready_q <= 1'b0;
         rd_valid_q <= 1'b0;  rd_sof_q <= 1'b0;  rd_eol_q <= 1'b0;  rd_last_q <= 1'b0;
         m_valid_q <= 1'b0;  m_sof_q <= 1'b0;  m_eol_q <= 1'b0;  m_last_q <= 1'b0;  m_data_q <= {2*DataWidth{1'b0}};
         skid_valid_q <= 1'b0;  skid_sof_q <= 1'b0;  skid_eol_q <= 1'b0;  skid_last_q <= 1'b0;
         skid_data_q <= {2*DataWidth{1'b0}};
      end else begin
         state_q <= state_d;  row_q <= row_d;  col_q <= col_d;  n_q <= n_d;  k_q <= k_d;
         issue_done_q <= issue_done_d;  s_ready_q <= s_ready_d;
         rd_valid_q <= rd_valid_d;  rd_sof_q <= rd_sof_d;  rd_eol_q <= rd_eol_d;  rd_last_q <= rd_last_d;
         m_valid_q <= m_valid_d;  m_sof_q <= m_sof_d;  m_eol_q <= m_eol_d;  m_last_q <= m_last_d;  m_data_q <= m_data_d;
         skid_valid_q <= skid_valid_d;  skid_sof_q <= skid_sof_d;  skid_eol_q <= skid_eol_d;
         skid_last_q <= skid_last_d;  skid_data_q <= skid_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_even_s) mem_even_q[wr_addr_s] <= s_data_i;
      if (we_odd_s) mem_odd_q[wr_addr_s] <= s_data_i;
      if (rd_en_s) begin
         rdata_even_q <= mem_even_q[rd_addr_even_s];
         rdata_odd_q  <= mem_odd_q[rd_addr_odd_s];
      end
   end

   assign s_ready_o = s_ready_q;
   assign m_valid_o = m_valid_q;
   assign m_sof_o   = m_sof_q;
   assign m_eol_o   = m_eol_q;
   assign m_data_o  = m_data_q;

`ifdef DWT_SYM_EXT_ERR_EN
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (geo_err_s) begin
         err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         else err_cnt_d = err_cnt_q;
      end else if (acc_s && s_sof_i) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dwt_sym_ext_feeder.sv
// Scoreboard bench for dwt_sym_ext_feeder: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_dwt_sym_ext_feeder;
   localparam int W = 16;

   typedef struct packed {
      logic         sof;
      logic         eol;
      logic [2*W-1:0] data;
   } beat_t;

   logic clk, rst, s_ready, s_valid, s_sof, s_eol, m_ready, m_valid, m_sof, m_eol;
   logic [W-1:0]   s_data;
   logic [2*W-1:0] m_data;
`ifdef DWT_SYM_EXT_ERR_EN
   logic       err;
   logic [7:0] err_cnt;
`endif

   beat_t exp_q[$];
   beat_t got_q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    last_hs = 0;
   bit    rand_ready = 1'b0;

   dwt_sym_ext_feeder #(.DataWidth(W), .MaximumSideSize(32)) dut (
      .clk_i(clk), .rst_i(rst), .s_ready_o(s_ready), .s_valid_i(s_valid), .s_sof_i(s_sof),
      .s_eol_i(s_eol), .s_data_i(s_data), .m_ready_i(m_ready), .m_valid_o(m_valid),
      .m_sof_o(m_sof), .m_eol_o(m_eol), .m_data_o(m_data)
`ifdef DWT_SYM_EXT_ERR_EN
      , .err_o(err), .err_cnt_o(err_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic beat_t got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return '0;
   endfunction

   // Downstream ready: held high, or pseudo-random when rand_ready is set.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      bit    stall;
      beat_t held, cur, e;
      stall = 1'b0;
      forever begin
         @(negedge clk);
         cur = {m_sof, m_eol, m_data};
         if (stall) chk("stall_hold", 64'({m_valid, cur}), 64'({1'b1, held}));
         stall = 1'b0;
         if (m_valid && m_ready) begin
            got_q.push_back(cur);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("beat%0d", got_q.size() - 1), 64'(cur), 64'(e));
            end
         end else if (m_valid) begin
            stall = 1'b1;
            held  = cur;
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic sof, input logic eol);
      int t;
      s_valid = 1'b1; s_sof = sof; s_eol = eol; s_data = d;
      t = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 2000) begin
            chk("s_ready_timeout", 64'(s_ready), 64'(1));
            s_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      last_hs = cyc;
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
   endtask

   task automatic send_tile(input int n, input int off);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            send(16'(r * n + c + off), (r == 0) && (c == 0), c == n - 1);
   endtask

   // Expected extended tile: pairs (4,3),(2,1),(0,1),(2,3)..(n-2,n-1),(n-2,n-3),(n-4,n-5).
   task automatic push_exp(input int n, input int off);
      int    ev[$], od[$];
      beat_t b;
      ev = '{4, 2};
      od = '{3, 1};
      for (int j = 0; j < n / 2; j++) begin
         ev.push_back(2 * j);
         od.push_back(2 * j + 1);
      end
      ev.push_back(n - 2); od.push_back(n - 3);
      ev.push_back(n - 4); od.push_back(n - 5);
      for (int p = 0; p < ev.size(); p++)
         for (int c = 0; c < n; c++) begin
            b.sof  = (p == 0) && (c == 0);
            b.eol  = (c == n - 1);
            b.data = {16'(od[p] * n + c + off), 16'(ev[p] * n + c + off)};
            exp_q.push_back(b);
         end
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !m_valid && s_ready) return;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int t;
      rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_s_ready", 64'(s_ready), 64'(0));
      chk("reset_m_outputs", 64'({m_valid, m_sof, m_eol, m_data}), 64'(0));
`ifdef DWT_SYM_EXT_ERR_EN
      chk("reset_err", 64'({err, err_cnt}), 64'(0));
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 64'(s_ready), 64'(1));

      // Stray beats in IDLE are swallowed without output.
      got_q.delete();
      for (int i = 1; i <= 10; i++) send(16'(i), 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_junk_no_output", 64'(got_q.size()), 64'(0));
      chk("idle_junk_ready", 64'(s_ready), 64'(1));

      // Nominal 16x16, continuous ready.
      got_q.delete();
      push_exp(16, 0);
      send_tile(16, 0);
      t = 0;
      while (!m_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("first_valid_latency", 64'(cyc - last_hs), 64'(2));
      wait_done(1000);
      chk("nominal_beats", 64'(got_q.size()), 64'(192));
      chk("nominal_beat0", 64'(got_at(0)), 64'({1'b1, 1'b0, 16'd48, 16'd64}));
      chk("nominal_r2c5", 64'(got_at(2 * 16 + 5)), 64'({1'b0, 1'b0, 16'd21, 16'd5}));
      chk("nominal_r10c0", 64'(got_at(10 * 16)), 64'({1'b0, 1'b0, 16'd208, 16'd224}));
      chk("nominal_r11c15", 64'(got_at(11 * 16 + 15)), 64'({1'b0, 1'b1, 16'd191, 16'd207}));

      // Same tile with a stalling consumer.
      got_q.delete();
      rand_ready = 1'b1;
      push_exp(16, 0);
      send_tile(16, 0);
      wait_done(3000);
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("stalled_beats", 64'(got_q.size()), 64'(192));

      // Width-5 tile: geometry error, discarded.
      got_q.delete();
      send_tile(5, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("width5_no_output", 64'(got_q.size()), 64'(0));
      chk("width5_idle_ready", 64'(s_ready), 64'(1));
`ifdef DWT_SYM_EXT_ERR_EN
      chk("width5_err", 64'({err, err_cnt}), 64'({1'b1, 8'd1}));
`endif

      // Fill restarted by s_sof at row 3 col 2; only the second tile is emitted.
      got_q.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < ((r == 3) ? 2 : 16); c++)
            send(16'(r * 16 + c + 1000), (r == 0) && (c == 0), c == 15);
      push_exp(16, 0);
      send_tile(16, 0);
      wait_done(1000);
      chk("restart_beats", 64'(got_q.size()), 64'(192));
`ifdef DWT_SYM_EXT_ERR_EN
      chk("restart_err_cleared", 64'({err, err_cnt}), 64'({1'b0, 8'd1}));
`endif

      // Reset pulse while emitting row 4, then a 6x6 tile.
      got_q.delete();
      push_exp(16, 0);
      send_tile(16, 0);
      t = 0;
      while (got_q.size() < 64 && t < 500) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("reached_row4", 64'(got_q.size() >= 64), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      chk("reset_drops_valid", 64'(m_valid), 64'(0));
      @(posedge clk);
      #1;
      chk("ready_after_emit_reset", 64'({m_valid, s_ready}), 64'({1'b0, 1'b1}));
      got_q.delete();
      push_exp(6, 0);
      send_tile(6, 0);
      wait_done(500);
      chk("tile6_beats", 64'(got_q.size()), 64'(42));
      chk("tile6_beat0", 64'(got_at(0)), 64'({1'b1, 1'b0, 16'd18, 16'd24}));
      chk("tile6_last", 64'(got_at(41)), 64'({1'b0, 1'b1, 16'd11, 16'd17}));

      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
